// File: rtl/pi_recv_pkg.sv
// pi_recv_pkg
//   Shared defaults and helpers for the Pi GPIO receive FIFO.
//   DATA_W_DEF / DEPTH_DEF / LED_W_DEF : default parameter values
//   btn_sel_t                          : board button select (peek index)
//   cnt_w(depth)                       : width of an occupancy counter holding 0..depth
package pi_recv_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int LED_W_DEF  = 6;

    typedef logic [1:0] btn_sel_t;

    // Counter must represent DEPTH itself, hence one bit more than the pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pi_recv_fifo_if.sv
// pi_recv_fifo_if
//   Bundles the GPIO push side, the valid/ready read port, status flags and the
//   LED debug view of pi_recv_fifo.
//   master : Pi/consumer side (drives gpio_data, write_enable, rd_ready, buttons)
//   slave  : FIFO side (drives rd_data, rd_valid, count, full, overflow, LED)
interface pi_recv_fifo_if
    import pi_recv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LED_W  = LED_W_DEF
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_W-1:0] gpio_data;
    logic              write_enable;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              overflow;
    btn_sel_t          buttons;
    logic [LED_W-1:0]  LED;

    modport master (
        output gpio_data, write_enable, rd_ready, buttons,
        input  rd_data, rd_valid, count, full, overflow, LED
    );

    modport slave (
        input  gpio_data, write_enable, rd_ready, buttons,
        output rd_data, rd_valid, count, full, overflow, LED
    );

endinterface

// File: rtl/pi_recv_mem.sv
// pi_recv_mem
//   DEPTH x DATA_W storage for the receive FIFO. No reset: contents are only
//   observable through entries the control logic has marked occupied.
//   clk_i                  : clock
//   we_i, waddr_i, wdata_i : synchronous write port
//   head_addr_i/_data_o    : asynchronous read port (FIFO head)
//   peek_addr_i/_data_o    : asynchronous read port (LED peek)
module pi_recv_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     head_addr_i,
    output logic [DATA_W-1:0] head_data_o,
    input  logic [AW-1:0]     peek_addr_i,
    output logic [DATA_W-1:0] peek_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign head_data_o = mem_q[head_addr_i];
    assign peek_data_o = mem_q[peek_addr_i];

endmodule

// File: rtl/pi_recv_fifo.sv
// pi_recv_fifo
//   Captures DATA_W-bit words strobed on GPIO into a DEPTH-entry circular FIFO
//   and presents them first-word-fall-through on a valid/ready read port.
//   pi_clk : sole clock
//   rst    : synchronous, active-high reset
//   bus    : pi_recv_fifo_if.slave (push, read port, count/full/overflow, LED)
//   Build option RECV_PEEK_EN: when defined, LED shows the entry selected by
//   buttons relative to the head; otherwise LED shows the last accepted word.
module pi_recv_fifo
    import pi_recv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LED_W  = LED_W_DEF
) (
    input logic           pi_clk,
    input logic           rst,
    pi_recv_fifo_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [LED_W-1:0] led_q, led_d;

    logic              rd_valid, full, push, pop;
    logic [PTR_W-1:0]  peek_addr;
    logic [DATA_W-1:0] head_data, peek_data;

    assign rd_valid = (count_q != '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop      = rd_valid && bus.rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = bus.write_enable && (!full || pop);

    // Truncation to PTR_W gives the mod-DEPTH wrap for free.
    assign peek_addr = rd_ptr_q + PTR_W'(bus.buttons);

    pi_recv_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i       (pi_clk),
        .we_i        (push),
        .waddr_i     (wr_ptr_q),
        .wdata_i     (bus.gpio_data),
        .head_addr_i (rd_ptr_q),
        .head_data_o (head_data),
        .peek_addr_i (peek_addr),
        .peek_data_o (peek_data)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (bus.write_enable && !push) ovf_d = 1'b1;
    end

    always_ff @(posedge pi_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // LED is registered from the current FIFO state, so it trails the edge
    // that changed that state by one cycle.
`ifdef RECV_PEEK_EN
    logic unused_peek;
    assign unused_peek = ^peek_data;

    always_comb begin
        led_d = '0;
        // Compare at 32 bits so a 2-bit select is never truncated against a narrow count.
        if (32'(bus.buttons) < 32'(count_q)) led_d = peek_data[LED_W-1:0];
    end
`else
    logic [LED_W-1:0] last_q;
    logic             unused_peek;
    assign unused_peek = ^{peek_data, bus.buttons};

    always_ff @(posedge pi_clk) begin
        if (rst)       last_q <= '0;
        else if (push) last_q <= bus.gpio_data[LED_W-1:0];
    end

    always_comb begin
        led_d = last_q;
    end
`endif

    always_ff @(posedge pi_clk) begin
        if (rst) led_q <= '0;
        else     led_q <= led_d;
    end

    assign bus.rd_data  = head_data;
    assign bus.rd_valid = rd_valid;
    assign bus.count    = count_q;
    assign bus.full     = full;
    assign bus.overflow = ovf_q;
    assign bus.LED      = led_q;

endmodule

// File: tb/tb_pi_recv_fifo.sv
// tb_pi_recv_fifo
//   Directed scenarios plus randomized traffic against a queue-based reference
//   model (DATA_W=8, DEPTH=4, LED_W=6).
module tb_pi_recv_fifo;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int LW = 6;

    logic pi_clk = 1'b0;
    logic rst    = 1'b1;
    always #5 pi_clk = ~pi_clk;

    pi_recv_fifo_if #(.DATA_W(DW), .DEPTH(DP), .LED_W(LW)) bus ();

    pi_recv_fifo #(.DATA_W(DW), .DEPTH(DP), .LED_W(LW)) dut (
        .pi_clk (pi_clk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: contents as a queue, head at index 0.
    logic [DW-1:0] mq[$];
    bit            m_ovf;
    logic [LW-1:0] m_last;
    logic [LW-1:0] m_led;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(bus.rd_valid), 32'(mq.size() != 0));
        check({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
        check({tag, ".full"},  32'(bus.full), 32'(mq.size() == DP));
        check({tag, ".ovf"},   32'(bus.overflow), 32'(m_ovf));
        check({tag, ".led"},   32'(bus.LED), 32'(m_led));
        if (mq.size() != 0) check({tag, ".data"}, 32'(bus.rd_data), 32'(mq[0]));
    endtask

    // One clock: inputs applied at negedge, model advanced at posedge,
    // outputs compared at the next negedge.
    task automatic step(input logic r, input logic we, input logic [DW-1:0] d,
                        input logic rdy, input logic [1:0] b, input string tag);
        bit            pop, acc;
        logic [LW-1:0] led_nx;
        rst              = r;
        bus.write_enable = we;
        bus.gpio_data    = d;
        bus.rd_ready     = rdy;
        bus.buttons      = b;
        @(posedge pi_clk);
`ifdef RECV_PEEK_EN
        led_nx = (int'(b) < mq.size()) ? mq[int'(b)][LW-1:0] : '0;
`else
        led_nx = m_last;
`endif
        if (r) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_last = '0;
            m_led  = '0;
        end else begin
            pop = (mq.size() != 0) && rdy;
            acc = we && ((mq.size() < DP) || pop);
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(d);
                m_last = d[LW-1:0];
            end
            if (we && !acc) m_ovf = 1'b1;
            m_led = led_nx;
        end
        @(negedge pi_clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, "rst");
        step(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, "rst");
    endtask

    initial begin
        bus.write_enable = 1'b0;
        bus.gpio_data    = '0;
        bus.rd_ready     = 1'b0;
        bus.buttons      = '0;
        mq.delete();
        m_ovf = 1'b0; m_last = '0; m_led = '0;
        @(negedge pi_clk);

        // Reset state
        do_reset();
        check("reset.count", 32'(bus.count), 32'd0);
        check("reset.led",   32'(bus.LED), 32'd0);

        // Three pushes, no reads
        step(1'b0, 1'b1, 8'h11, 1'b0, 2'd0, "t1");
        step(1'b0, 1'b1, 8'h22, 1'b0, 2'd0, "t1");
        step(1'b0, 1'b1, 8'h33, 1'b0, 2'd0, "t1");
        check("t1.count", 32'(bus.count), 32'd3);
        check("t1.data",  32'(bus.rd_data), 32'h11);
        check("t1.full",  32'(bus.full), 32'd0);

        // Fill, overflow, drain
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 8'(i * 8'h11), 1'b0, 2'd0, "t2fill");
        step(1'b0, 1'b1, 8'h55, 1'b0, 2'd0, "t2ovf");
        check("t2.full", 32'(bus.full), 32'd1);
        check("t2.ovf",  32'(bus.overflow), 32'd1);
        check("t2.data", 32'(bus.rd_data), 32'h11);
        for (int i = 1; i <= 4; i++) begin
            check("t2.drain", 32'(bus.rd_data), 32'(i * 8'h11));
            step(1'b0, 1'b0, 8'h00, 1'b1, 2'd0, "t2drain");
        end
        check("t2.empty", 32'(bus.rd_valid), 32'd0);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 8'(i * 8'h11), 1'b0, 2'd0, "t3fill");
        step(1'b0, 1'b1, 8'h66, 1'b1, 2'd0, "t3pp");
        check("t3.count", 32'(bus.count), 32'd4);
        check("t3.ovf",   32'(bus.overflow), 32'd0);
        check("t3.head",  32'(bus.rd_data), 32'h22);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 2'd0, "t3drain");
        check("t3.last", 32'(bus.rd_data), 32'h66);
        step(1'b0, 1'b0, 8'h00, 1'b1, 2'd0, "t3drain");

        // Empty with push and ready together: push only
        step(1'b0, 1'b1, 8'h3C, 1'b1, 2'd0, "t4");
        check("t4.valid", 32'(bus.rd_valid), 32'd1);
        check("t4.data",  32'(bus.rd_data), 32'h3C);
        check("t4.count", 32'(bus.count), 32'd1);

        // Mid-stream reset
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), 1'(i % 2), 2'd0, "t5");
        step(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, "t5rst");
        check("t5.count", 32'(bus.count), 32'd0);
        check("t5.ovf",   32'(bus.overflow), 32'd0);
        check("t5.led",   32'(bus.LED), 32'd0);

        // LED view
        step(1'b0, 1'b1, 8'h01, 1'b0, 2'd0, "t6");
        step(1'b0, 1'b1, 8'h02, 1'b0, 2'd0, "t6");
        step(1'b0, 1'b1, 8'h03, 1'b0, 2'd0, "t6");
        step(1'b0, 1'b0, 8'h00, 1'b0, 2'd2, "t6");
        step(1'b0, 1'b0, 8'h00, 1'b0, 2'd2, "t6");
        check("t6.led2", 32'(bus.LED), 32'h03);
        step(1'b0, 1'b0, 8'h00, 1'b0, 2'd3, "t6");
        step(1'b0, 1'b0, 8'h00, 1'b0, 2'd3, "t6");
`ifdef RECV_PEEK_EN
        check("t6.led3", 32'(bus.LED), 32'h00);
`else
        check("t6.led3", 32'(bus.LED), 32'h03);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 99) < 60),
                 8'($urandom),
                 1'($urandom_range(0, 99) < 45),
                 2'($urandom),
                 "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
